// File: rtl/hilo_mdu.sv
//==============================================================================
// Module   : hilo_mdu
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU unit that produces {hi, lo} and
//            drives the HI/LO write port. Optional: MDU_DIVZ_FAST_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hilo_mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        valid,
    output logic [63:0] result,
    output logic        hilo_we,
    output logic [2:0]  flag
`ifdef MDU_DIVZ_FAST_EN
    ,
    output logic        divz
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [4:0]  c_last_iter = 5'd31;
    localparam logic [31:0] c_all_ones  = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_next;
    logic        w_launch;

    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_div;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;

    logic        r_valid;
    logic        r_busy;
    logic [63:0] r_result;

    logic        w_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_done;

    // MULT and DIV share op[0]=0 as the signed flavour
    assign w_signed  = ~r_op[0];
    assign w_mul_a   = {{32{w_signed & r_a[31]}}, r_a};
    assign w_mul_b   = {{32{w_signed & r_b[31]}}, r_b};
    assign w_product = w_mul_a * w_mul_b;

    assign w_abs_a = (~op[0] & a[31]) ? (32'd0 - a) : a;
    assign w_abs_b = (~op[0] & b[31]) ? (32'd0 - b) : b;

    // Restoring step: remainder < divisor, so the shifted value fits 33 bits
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[32];

    assign w_quo_fix = (w_signed & (r_a[31] ^ r_b[31])) ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = (w_signed & r_a[31]) ? (32'd0 - r_rem) : r_rem;

    assign w_done = (r_state == DONE) && !cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        if (cancel) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    w_next = IDLE;
                    if (start) begin
                        w_launch = 1'b1;
`ifdef MDU_DIVZ_FAST_EN
                        w_next = (op[1] && (b != 32'd0)) ? DIV : MUL;
`else
                        w_next = op[1] ? DIV : MUL;
`endif
                    end
                end
                MUL:     w_next = DONE;
                DIV:     w_next = (r_cnt == c_last_iter) ? FIX : DIV;
                FIX:     w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 2'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_div    <= 32'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_prod   <= 64'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= 64'd0;
        end else begin
            if (w_launch) begin
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_quo <= w_abs_a;
                r_div <= w_abs_b;
                r_rem <= 32'd0;
                r_cnt <= 5'd0;
            end else begin
                case (r_state)
                    // A divide only reaches MUL when it is a fast divide-by-zero
                    MUL: r_prod <= r_op[1] ? {r_a, c_all_ones} : w_product;
                    DIV: begin
                        r_quo <= {r_quo[30:0], w_ge};
                        r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
                        r_cnt <= r_cnt + 5'd1;
                    end
                    FIX: r_prod <= (r_b == 32'd0) ? {r_a, c_all_ones}
                                                  : {w_rem_fix, w_quo_fix};
                    default: ;
                endcase
            end

            r_valid <= w_done;
            if (w_done) begin
                r_result <= r_prod;
            end
            // Busy drops in the valid cycle even when a back-to-back op launched
            r_busy <= (w_next != IDLE) && (r_state != DONE);
        end
    end

`ifdef MDU_DIVZ_FAST_EN
    logic r_divz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_divz <= 1'b0;
        end else begin
            r_divz <= w_done && r_op[1] && (r_b == 32'd0);
        end
    end

    assign divz = r_divz;
`endif

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign result  = r_result;
    assign hilo_we = r_valid;
    assign flag    = {3{r_valid}};

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
//==============================================================================
// Module   : tb_hilo_mdu
// Brief    : Self-checking bench for hilo_mdu against an arithmetic reference.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hilo_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        valid;
    logic [63:0] result;
    logic        hilo_we;
    logic [2:0]  flag;
`ifdef MDU_DIVZ_FAST_EN
    logic        divz;
`endif

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    hilo_mdu dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .busy    (busy),
        .valid   (valid),
        .result  (result),
        .hilo_we (hilo_we),
`ifdef MDU_DIVZ_FAST_EN
        .divz    (divz),
`endif
        .flag    (flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx;
        longint      sy;
        int          q;
        int          rm;
        logic [63:0] r;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                r  = sx * sy;
            end
            2'b01: r = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0)
                    r = {x, 32'hFFFF_FFFF};
                else if (o == 2'b11)
                    r = {x % y, x / y};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    q  = $signed(x) / $signed(y);
                    rm = $signed(x) % $signed(y);
                    r  = {rm, q};
                end
            end
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
        int lat;
        lat = o[1] ? 34 : 2;
`ifdef MDU_DIVZ_FAST_EN
        if (o[1] && y == 32'd0) lat = 2;
`else
        if (y == 32'hDEAD_BEEF) lat = 34;
`endif
        return lat;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        int          n;
        logic [63:0] exp;
        exp   = ref_model(o, x, y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs: the unit must work from its latched operands
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
        check({tag, ":busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!valid && n < 60) begin
            start = (n == 4);   // ignored while busy
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, ":lat"}, 64'(n), 64'(exp_latency(o, y)));
        check({tag, ":res"}, result, exp);
        check({tag, ":we"}, 64'(hilo_we), 64'd1);
        check({tag, ":flag"}, 64'(flag), 64'd7);
        check({tag, ":nbusy"}, 64'(busy), 64'd0);
`ifdef MDU_DIVZ_FAST_EN
        check({tag, ":divz"}, 64'(divz), 64'(o[1] && y == 32'd0));
`endif
        last_res = exp;
        tick();
        check({tag, ":pulse"}, 64'(valid), 64'd0);
        check({tag, ":hold"}, result, last_res);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic        seen;
        int          sel;

        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'd0;
        a      = 32'd0;
        b      = 32'd0;
        repeat (3) tick();
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:valid", 64'(valid), 64'd0);
        check("rst:res", result, 64'd0);
        check("rst:flag", 64'(flag), 64'd0);
        check("rst:we", 64'(hilo_we), 64'd0);
        rst      = 1'b0;
        last_res = 64'd0;
        tick();

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg:abs", last_res, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 2'b11, 32'd100, 32'd7);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_z", 2'b11, 32'd5, 32'd0);
        run_op("div_z", 2'b10, 32'hFFFF_FF00, 32'd0);

        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom_range(0, 3));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            if (sel == 1) y = $urandom_range(1, 20);
            if (sel == 2) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            if (sel == 3) x = 32'd0 - $urandom_range(1, 1000);
            run_op("rand", o, x, y);
        end

        // Cancel mid-divide at E10
        op    = 2'b11;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel:busy", 64'(busy), 64'd0);
        check("cancel:valid", 64'(valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (valid) seen = 1'b1;
        end
        check("cancel:novalid", 64'(seen), 64'd0);
        check("cancel:hold", result, last_res);

        // Start and cancel together
        op     = 2'b01;
        a      = 32'd9;
        b      = 32'd9;
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("stcan:busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (valid) seen = 1'b1;
        end
        check("stcan:novalid", 64'(seen), 64'd0);

        // Back-to-back: MULTU issued in the DONE cycle of a DIV
        op    = 2'b10;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (33) tick();
        op    = 2'b01;
        a     = 32'h0001_0000;
        b     = 32'h0003_0005;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b:valid1", 64'(valid), 64'd1);
        check("b2b:busy1", 64'(busy), 64'd0);
        check("b2b:res1", result, ref_model(2'b10, 32'hFFFF_FFF9, 32'd2));
        tick();
        check("b2b:gap", 64'(valid), 64'd0);
        tick();
        check("b2b:valid2", 64'(valid), 64'd1);
        check("b2b:res2", result, ref_model(2'b01, 32'h0001_0000, 32'h0003_0005));
        tick();

        // Reset at E5 of a divide
        op    = 2'b10;
        a     = 32'd12345;
        b     = 32'hFFFF_FFF9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst:res", result, 64'd0);
        check("mrst:valid", 64'(valid), 64'd0);
        check("mrst:busy", 64'(busy), 64'd0);
        check("mrst:flag", 64'(flag), 64'd0);
        check("mrst:we", 64'(hilo_we), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (valid) seen = 1'b1;
        end
        check("mrst:novalid", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
